// File: rtl/project_cpu_gen.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/(INDIR)/EXEC over a single-port RAM with a
// one-cycle read latency and a mem_ready stall handshake; direct ops take 3 cycles, indirect 4.
module project_cpu_gen #(
    parameter int DW        = 16,
    parameter int AW        = 13,
    parameter int INDIR_PTR = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] data_fromRAM,
    input  logic          mem_ready,
    output logic          wrEn,
    output logic [AW-1:0] addr_toRAM,
    output logic [DW-1:0] data_toRAM,
    output logic [AW-1:0] PC,
    output logic [DW-1:0] W,
    output logic          retire
);
    localparam int            SW         = $clog2(DW);
    localparam logic [DW-1:0] DW_V       = DW'(DW);
    localparam logic [AW-1:0] INDIR_ADDR = AW'(INDIR_PTR);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_NOR   = 3'd1;
    localparam logic [2:0] OP_SHIFT = 3'd2;
    localparam logic [2:0] OP_ROT   = 3'd3;
    localparam logic [2:0] OP_CMP   = 3'd4;
    localparam logic [2:0] OP_BZ    = 3'd5;
    localparam logic [2:0] OP_LD    = 3'd6;
    localparam logic [2:0] OP_ST    = 3'd7;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        INDIR  = 2'd2,
        EXEC   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] w_q, w_d;
    logic [2:0]    opcode_q, opcode_d;
    logic [AW-1:0] operand_q, operand_d;
    logic [AW-1:0] addr_q, addr_d;

    logic [AW-1:0]   addr_raw;
    logic [DW-1:0]   dout_raw;
    logic            wr_raw;
    logic            ret_raw;
    logic [DW-1:0]   alu_w;
    logic [DW-1:0]   m;
    logic            m_small;
    logic [SW-1:0]   amt;
    logic [2*DW-1:0] dbl;
    logic [2*DW-1:0] rot_r_full;
    logic [2*DW-1:0] rot_l_full;

    // Instruction bits between the opcode and the operand carry no meaning.
    logic unused_ok;
    assign unused_ok = ^data_fromRAM;

    // Amounts >= DW switch direction and use only the low log2(DW) bits.
    always_comb begin
        m          = data_fromRAM;
        m_small    = (m < DW_V);
        amt        = m[SW-1:0];
        dbl        = {w_q, w_q};
        rot_r_full = dbl >> amt;
        rot_l_full = dbl << amt;
        alu_w      = w_q;
        case (opcode_q)
            OP_ADD:   alu_w = w_q + m;
            OP_NOR:   alu_w = ~(w_q | m);
            OP_SHIFT: alu_w = m_small ? (w_q >> amt) : (w_q << amt);
            OP_ROT:   alu_w = m_small ? rot_r_full[DW-1:0] : rot_l_full[2*DW-1:DW];
            OP_CMP:   alu_w = (w_q < m) ? '1 : ((w_q == m) ? '0 : DW'(1));
            OP_LD:    alu_w = m;
            default:  alu_w = w_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        w_d       = w_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        addr_d    = addr_q;
        addr_raw  = addr_q;
        wr_raw    = 1'b0;
        dout_raw  = '0;
        ret_raw   = 1'b0;
        case (state_q)
            FETCH: begin
                addr_d   = pc_q;
                addr_raw = pc_q;
                state_d  = DECODE;
            end
            DECODE: begin
                if (mem_ready) begin
                    opcode_d  = data_fromRAM[DW-1:DW-3];
                    operand_d = data_fromRAM[AW-1:0];
                    if (data_fromRAM[AW-1:0] != '0) begin
                        addr_d  = data_fromRAM[AW-1:0];
                        state_d = EXEC;
                    end else begin
                        addr_d  = INDIR_ADDR;
                        state_d = INDIR;
                    end
                end
                addr_raw = addr_d;
            end
            INDIR: begin
                if (mem_ready) begin
                    operand_d = data_fromRAM[AW-1:0];
                    addr_d    = data_fromRAM[AW-1:0];
                    state_d   = EXEC;
                end
                addr_raw = addr_d;
            end
            EXEC: begin
                addr_raw = operand_q;
                if (opcode_q == OP_ST) begin
                    wr_raw   = 1'b1;
                    dout_raw = w_q;
                end
                if (mem_ready) begin
                    ret_raw = 1'b1;
                    w_d     = alu_w;
                    pc_d    = (opcode_q == OP_BZ && m == '0) ? w_q[AW-1:0] : pc_q + AW'(1);
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
                pc_d    = '0;
                w_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            w_q       <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            w_q       <= w_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            addr_q    <= addr_d;
        end
    end

    // Bus outputs are forced idle for as long as reset is held, whatever the state.
    assign wrEn       = rst & wr_raw;
    assign retire     = rst & ret_raw;
    assign addr_toRAM = rst ? addr_raw : '0;
    assign data_toRAM = rst ? dout_raw : '0;
    assign PC         = pc_q;
    assign W          = w_q;

endmodule

// File: doc/project_cpu_gen.md
PROJECT_CPU_GEN -- requirements
Module: project_cpu_gen

Interface
REQ-001 Parameter DW, default 16: data and instruction width; power of two, >= 8.
REQ-002 Parameter AW, default 13: address and PC width; AW <= DW-3.
REQ-003 Parameter INDIR_PTR, default 4: RAM address holding the pointer used for indirect operands.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset (sampled at posedge clk, 0 = reset).
REQ-006 data_fromRAM  input  DW  read data; valid the cycle after its address was presented.
REQ-007 mem_ready  input  1  RAM handshake; 1 = read data valid / write accepted this cycle.
REQ-008 wrEn  output  1  RAM write enable.
REQ-009 addr_toRAM  output  AW  RAM address.
REQ-010 data_toRAM  output  DW  RAM write data.
REQ-011 PC  output  AW  program counter (testbench visibility).
REQ-012 W  output  DW  accumulator (testbench visibility).
REQ-013 retire  output  1  one-cycle pulse when an instruction completes.

Function
REQ-014 Instruction format: opcode = bits [DW-1:DW-3]; operand = bits [AW-1:0]; bits [DW-4:AW] ignored.
REQ-015 States: FETCH, DECODE, INDIR, EXEC; any unused encoding goes to FETCH with PC=0, W=0.
REQ-016 FETCH: addr_toRAM=PC, wrEn=0 -> DECODE unconditionally.
REQ-017 DECODE: latch opcode/operand from data_fromRAM; operand!=0 -> addr=operand, go to EXEC; operand==0 -> addr=INDIR_PTR, go to INDIR.
REQ-018 INDIR: effective operand = data_fromRAM[AW-1:0]; addr=that value; go to EXEC.
REQ-019 EXEC: consume data_fromRAM (value M), update W/PC per opcode, pulse retire, go to FETCH.
REQ-020 Latency with mem_ready held 1: direct 3 cycles, indirect 4 cycles, FETCH to FETCH.
REQ-021 DECODE, INDIR, EXEC advance only in a cycle with mem_ready=1; otherwise hold state and all registers, re-drive the pending address from an internal register, no retire.
REQ-022 Opcodes on M: 000 ADD, W=W+M mod 2^DW; 001 NOR, W=~(W|M); 010 SHIFT, M<DW -> W>>M logical, else W<<M[log2(DW)-1:0].
REQ-023 Opcodes: 011 ROT, M<DW -> rotate right by M, else rotate left by M[log2(DW)-1:0]; amount 0 leaves W unchanged.
REQ-024 Opcodes: 100 CMP unsigned, W = all-ones if W<M, 0 if W==M, 1 if W>M.
REQ-025 Opcodes: 101 BZ, M==0 -> PC=W[AW-1:0], else PC=PC+1; 110 LD, W=M.
REQ-026 Opcode 111 ST: in EXEC drive wrEn=1, addr=operand, data_toRAM=W; hold all three until mem_ready=1; then retire.
REQ-027 Every non-BZ instruction sets PC=PC+1 at retire; PC wraps from 2^AW-1 to 0.
REQ-028 wrEn=1 only in EXEC for ST; otherwise wrEn=0 and data_toRAM=0.
REQ-029 Outputs wrEn, addr_toRAM, data_toRAM, retire are combinational from state; PC, W are registers.

Reset
REQ-030 rst=0 at a posedge: state=FETCH, PC=0, W=0, opcode/operand/pending-address registers=0.
REQ-031 While rst=0: wrEn=0, addr_toRAM=0, data_toRAM=0, retire=0, regardless of state or mem_ready.
REQ-032 Reset mid-instruction, including a stalled ST, abandons it; no write issued, no retire, restart at PC=0.

Verification
REQ-033 Direct ADD: RAM[0]=0x0064, RAM[100]=5, W=0, mem_ready=1 -> W=5, PC=1, retire 3 cycles after FETCH.
REQ-034 Indirect LD: RAM[0]=0xC000, RAM[4]=0x0020, RAM[0x20]=0xBEEF -> W=0xBEEF after 4 cycles, PC=1.
REQ-035 ST with stall: W=0x1234, instr 0xE050, mem_ready=0 for 3 EXEC cycles -> wrEn/addr=0x50/data=0x1234 held 4 cycles, one write, one retire.
REQ-036 SHIFT/ROT: W=0x8001; M=1 SHIFT -> 0x4000; M=17 SHIFT -> 0x0002; M=1 ROT -> 0xC000; M=16 ROT -> 0x8001.
REQ-037 BZ and CMP: W=0x0010, M=0 BZ -> PC=0x0010; W=3, CMP M=7 -> 0xFFFF; M=3 -> 0; M=2 -> 1.
REQ-038 Reset mid-stall: rst=0 during stalled ST -> no write, PC=0, W=0; DW=32/AW=16 build repeats REQ-033.
